// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one compare unit between two requesters.
// Three-state sequencer (IDLE/EVAL/DONE) with registered outputs and an op counter.
module cmp_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             res,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t           r_state, w_state;
  logic             r_rr, w_rr;
  logic             r_own, w_own;
  logic [WIDTH-1:0] r_x, w_x;
  logic [WIDTH-1:0] r_y, w_y;
  logic [1:0]       r_op, w_op;
  logic             r_gnt0, w_gnt0;
  logic             r_gnt1, w_gnt1;
  logic             r_done0, w_done0;
  logic             r_done1, w_done1;
  logic             r_res, w_res;
  logic             r_busy, w_busy;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             w_pick1;

  function automatic logic f_cmp(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       op
  );
    logic r;
    r = 1'b0;
    unique case (op)
      2'b00: r = (a == b);
      2'b01: r = (a < b);
      2'b10: r = (a > b);
      2'b11: r = (a != b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Requester 1 wins when alone, or when both ask and the pointer favours it.
  assign w_pick1 = req1 & (~req0 | r_rr);

  always_comb begin
    w_state = r_state;
    w_rr    = r_rr;
    w_own   = r_own;
    w_x     = r_x;
    w_y     = r_y;
    w_op    = r_op;
    w_gnt0  = r_gnt0;
    w_gnt1  = r_gnt1;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    w_res   = r_res;
    w_cnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          w_state = S_EVAL;
          w_own   = w_pick1;
          w_x     = w_pick1 ? x1 : x0;
          w_y     = w_pick1 ? y1 : y0;
          w_op    = w_pick1 ? op1 : op0;
          w_gnt0  = ~w_pick1;
          w_gnt1  = w_pick1;
        end
      end
      S_EVAL: begin
        w_state = S_DONE;
        w_res   = f_cmp(r_x, r_y, r_op);
        w_done0 = ~r_own;
        w_done1 = r_own;
        w_cnt   = r_cnt + CNT_W'(1);
        w_rr    = ~r_own;
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_res   = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_res   = 1'b0;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_own   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_op    <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_res   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_rr    <= w_rr;
      r_own   <= w_own;
      r_x     <= w_x;
      r_y     <= w_y;
      r_op    <= w_op;
      r_gnt0  <= w_gnt0;
      r_gnt1  <= w_gnt1;
      r_done0 <= w_done0;
      r_done1 <= w_done1;
      r_res   <= w_res;
      r_busy  <= w_busy;
      r_cnt   <= w_cnt;
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign res    = r_res;
  assign busy   = r_busy;
  assign op_cnt = r_cnt;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed-vector bench for cmp_arbiter.
// Each scenario task drives stimulus and checks outputs inline.
module tb_cmp_arbiter;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] x0, y0, x1, y1;
  logic [1:0]       op0, op1;
  logic             gnt0, gnt1, done0, done1, res, busy;
  logic [CNT_W-1:0] op_cnt;

  int vecs;
  int errs;

  cmp_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x0(x0), .y0(y0), .op0(op0),
    .req1(req1), .x1(x1), .y1(y1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .res(res), .busy(busy), .op_cnt(op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst = 1'b1;
    req0 = 0; req1 = 0;
    x0 = 0; y0 = 0; op0 = 0;
    x1 = 0; y1 = 0; op1 = 0;
    repeat (2) @(posedge clk);
    #1;
    got = {gnt0, gnt1, done0, done1, res, busy, 1'b0};
    vecs++;
    if (got !== 7'b0 || op_cnt !== 8'd0) begin
      errs++;
      $display("FAIL reset: outs=%b cnt=%0d want 0", got, op_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_eq_basic();
    @(negedge clk);
    req0 = 1; x0 = 5; y0 = 5; op0 = 2'b00;
    @(posedge clk); #1;
    vecs++;
    if (gnt0 !== 1 || gnt1 !== 0 || done0 !== 0 || busy !== 1) begin
      errs++;
      $display("FAIL eq_grant: gnt0=%b gnt1=%b done0=%b busy=%b want 1 0 0 1",
               gnt0, gnt1, done0, busy);
    end
    @(posedge clk); #1;
    vecs++;
    if (done0 !== 1 || res !== 1 || op_cnt !== 8'd1 || done1 !== 0) begin
      errs++;
      $display("FAIL eq_done: done0=%b res=%b cnt=%0d want 1 1 1",
               done0, res, op_cnt);
    end
    @(negedge clk);
    req0 = 0;
    @(posedge clk); #1;
    vecs++;
    if (busy !== 0 || gnt0 !== 0 || done0 !== 0 || res !== 0) begin
      errs++;
      $display("FAIL eq_idle: busy=%b gnt0=%b done0=%b res=%b want 0",
               busy, gnt0, done0, res);
    end
  endtask

  task automatic test_req1_ops();
    logic [3:0] tx [4] = '{4'd0, 4'd0, 4'd0, 4'd15};
    logic [3:0] ty [4] = '{4'd15, 4'd15, 4'd15, 4'd15};
    logic [1:0] top[4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic       tr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req1 = 1; x1 = tx[i]; y1 = ty[i]; op1 = top[i];
      @(posedge clk); #1;
      vecs++;
      if (gnt1 !== 1 || gnt0 !== 0) begin
        errs++;
        $display("FAIL req1_grant[%0d]: gnt1=%b gnt0=%b want 1 0",
                 i, gnt1, gnt0);
      end
      @(posedge clk); #1;
      vecs++;
      if (done1 !== 1 || done0 !== 0 || res !== tr[i]) begin
        errs++;
        $display("FAIL req1_res[%0d]: done1=%b res=%b want 1 %b",
                 i, done1, res, tr[i]);
      end
      @(negedge clk);
      req1 = 0;
      @(posedge clk);
    end
  endtask

  task automatic test_fairness();
    logic want1;
    apply_reset();
    req0 = 1; x0 = 1; y0 = 2; op0 = 2'b01;
    req1 = 1; x1 = 3; y1 = 3; op1 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      want1 = k[0];
      @(posedge clk); #1;
      vecs++;
      if (gnt1 !== want1 || gnt0 !== !want1) begin
        errs++;
        $display("FAIL fair_grant[%0d]: gnt0=%b gnt1=%b want1=%b",
                 k, gnt0, gnt1, want1);
      end
      @(posedge clk); #1;
      vecs++;
      if (done1 !== want1 || done0 !== !want1 || res !== !want1) begin
        errs++;
        $display("FAIL fair_done[%0d]: done0=%b done1=%b res=%b want1=%b",
                 k, done0, done1, res, want1);
      end
      @(posedge clk); #1;
      vecs++;
      if (done0 === 1 || done1 === 1 || busy !== 0) begin
        errs++;
        $display("FAIL fair_idle[%0d]: done0=%b done1=%b busy=%b want 0",
                 k, done0, done1, busy);
      end
    end
    @(negedge clk);
    req0 = 0; req1 = 0;
    vecs++;
    if (op_cnt !== 8'd4) begin
      errs++;
      $display("FAIL fair_cnt: op_cnt=%0d want 4", op_cnt);
    end
  endtask

  task automatic test_latch();
    @(negedge clk);
    req0 = 1; x0 = 3; y0 = 3; op0 = 2'b00;
    @(posedge clk); #1;
    x0 = 7;
    req0 = 0;
    @(posedge clk); #1;
    vecs++;
    if (done0 !== 1 || res !== 1) begin
      errs++;
      $display("FAIL latch: done0=%b res=%b want 1 1", done0, res);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req1 = 1; x1 = 2; y1 = 4; op1 = 2'b01;
    @(posedge clk); #1;
    vecs++;
    if (gnt1 !== 1) begin
      errs++;
      $display("FAIL mid_grant: gnt1=%b want 1", gnt1);
    end
    rst = 1;
    #1;
    vecs++;
    if ({gnt0, gnt1, done0, done1, res, busy} !== 6'b0 || op_cnt !== 8'd0) begin
      errs++;
      $display("FAIL mid_clear: outs=%b cnt=%0d want 0",
               {gnt0, gnt1, done0, done1, res, busy}, op_cnt);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      vecs++;
      if (done1 !== 0 || op_cnt !== 8'd0) begin
        errs++;
        $display("FAIL mid_hold[%0d]: done1=%b cnt=%0d want 0 0",
                 c, done1, op_cnt);
      end
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    vecs++;
    if (gnt1 !== 1 || busy !== 1) begin
      errs++;
      $display("FAIL mid_regrant: gnt1=%b busy=%b want 1 1", gnt1, busy);
    end
    @(posedge clk); #1;
    vecs++;
    if (done1 !== 1 || res !== 1 || op_cnt !== 8'd1) begin
      errs++;
      $display("FAIL mid_done: done1=%b res=%b cnt=%0d want 1 1 1",
               done1, res, op_cnt);
    end
    @(negedge clk);
    req1 = 0;
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] want;
    apply_reset();
    req0 = 1; x0 = 9; y0 = 4; op0 = 2'b10;
    for (int i = 0; i < 257; i++) begin
      want = CNT_W'(i + 1);
      @(posedge clk); #1;
      vecs++;
      if (gnt0 !== 1 || done0 !== 0) begin
        errs++;
        $display("FAIL b2b_grant[%0d]: gnt0=%b done0=%b want 1 0",
                 i, gnt0, done0);
      end
      @(posedge clk); #1;
      vecs++;
      if (done0 !== 1 || res !== 1 || op_cnt !== want) begin
        errs++;
        $display("FAIL b2b_done[%0d]: done0=%b res=%b cnt=%0d want 1 1 %0d",
                 i, done0, res, op_cnt, want);
      end
      if (i == 256) begin
        @(negedge clk);
        req0 = 0;
      end
      @(posedge clk); #1;
      vecs++;
      if (busy !== 0 || done0 !== 0) begin
        errs++;
        $display("FAIL b2b_idle[%0d]: busy=%b done0=%b want 0 0",
                 i, busy, done0);
      end
    end
    vecs++;
    if (op_cnt !== 8'd1) begin
      errs++;
      $display("FAIL b2b_wrap: op_cnt=%0d want 1", op_cnt);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_eq_basic();
    test_req1_ops();
    test_fairness();
    test_latch();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit magnitude/equality compare unit between two requesters.
- Each requester presents an operand pair and an opcode, holds req, and receives a one-cycle done pulse with a 1-bit result.
- Sits between ALU front-end requesters and the comparison datapath.
- Also keeps a wrapping count of completed operations for debug.

Parameters:
- WIDTH, 4, operand width in bits (unsigned).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 request; held until its done0 pulse.
- x0  in  WIDTH  requester 0 operand x.
- y0  in  WIDTH  requester 0 operand y.
- op0  in  2  requester 0 opcode.
- req1, x1, y1, op1  in  1/WIDTH/WIDTH/2  same meaning for requester 1.
- gnt0  out  1  requester 0 currently owns the compare unit (EVAL/DONE).
- gnt1  out  1  same for requester 1.
- done0  out  1  one-cycle pulse: requester 0 result valid.
- done1  out  1  same for requester 1.
- res  out  1  compare result; valid only while done0 or done1 is high.
- busy  out  1  state != IDLE.
- op_cnt  out  CNT_W  completed operations, wraps.

Behaviour:
- Reset: clock and reset are fixed as one clock, clk; reset rst is asynchronous and active-high.
  - On rst, immediately force: state=IDLE, rr pointer=0, gnt0=gnt1=done0=done1=res=busy=0, op_cnt=0.
- Opcodes (unsigned compare):
  - 00 EQ: x==y
  - 01 LT: x<y
  - 10 GT: x>y
  - 11 NE: x!=y
- FSM states: IDLE, EVAL, DONE. All outputs are registered.
- IDLE:
  - req0/req1 are sampled only in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester selected by the rr pointer.
  - On grant, latch x, y, op of the winner, set the matching gnt, and go to EVAL.
  - If no request, stay in IDLE.
- EVAL:
  - Compute the compare on the latched operands and register it into res.
  - Assert the winner's done in the next state; go to DONE.
  - Operand or req changes during EVAL/DONE are ignored.
- DONE:
  - done for the winner is high for exactly this one cycle; res is valid.
  - op_cnt += 1 (wraps at 2^CNT_W).
  - rr pointer := the other requester.
  - Next edge: state goes to IDLE, and gnt, done, and res clear to 0.
- Latency:
  - req sampled at edge E0 → gnt high after E0 → done and res high after E1 → IDLE after E2.
  - Throughput is one operation per 3 cycles.
- Handshake:
  - Requester must deassert req in the cycle following its done pulse.
  - A req still high at the first IDLE sample is treated as a new request.
- Fairness:
  - The pointer flips after every completion, so under continuous dual requests grants alternate 0,1,0,1…
  - A single requester is served back-to-back regardless of the pointer.
- Reset mid-operation:
  - Operation is abandoned and no done is emitted.
  - op_cnt is not incremented; pointer returns to 0.
- Only one of gnt0/gnt1 and one of done0/done1 may be high at any time.
- busy=1 in EVAL and DONE.

Test Plan:
- Reset release, req0=1, x0=5, y0=5, op0=EQ → gnt0 after 1 edge, done0=1 with res=1 after 2 edges, op_cnt=1, busy low afterwards.
- req1=1, x1=0, y1=15: with op1=LT → res=1; with op1=GT → res=0; with op1=NE → res=1; with x1=15, y1=15, op1=NE → res=0.
- Both reqs held continuously from reset (pointer=0) → completion order 0,1,0,1 across 4 ops; done0 and done1 never simultaneously high; op_cnt=4.
- req0 granted with x0=3, y0=3, EQ; x0 changed to 7 during EVAL → res=1 (latched operands used).
- Assert rst while in EVAL for requester 1 → all outputs 0 immediately, no done1 pulse, op_cnt=0; after release, req1 is re-served normally.
- Single requester issues 2^CNT_W+1 back-to-back ops (CNT_W=8, 257 ops) → op_cnt wraps to 1; each op completes 3 cycles apart.
